// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioning path: debounce FSM states and
// the board key index map used by the downstream timer logic.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int NUM_KEYS  = 4;

  // Board key positions inside the 4-bit key vectors.
  localparam int KEY_RESET = 0;
  localparam int KEY_START = 1;
  localparam int KEY_WRITE = 2;
  localparam int KEY_SHOW  = 3;

  // Larger of two cycle counts; sizes the per-key counter.
  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the raw board pins and the conditioned key events.
// master: drives raw keys and consumes events; slave: the conditioner.
interface key_conditioner_if;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  modport master (
    output key_n,
    input  key_level, key_press, key_release, key_long
  );

  modport slave (
    input  key_n,
    output key_level, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_conditioner_debounce.sv
// key_debounce: one key lane -- 2-flop synchronizer, debounce FSM and counter.
// Build option KEY_CONDITIONER_LONG_PRESS_EN adds a long-press pulse; without
// it long_o is tied low and no long-press counter exists.
module key_debounce
  import timer_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int LP_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CNT_W = $clog2(max_cycles(DB_CYCLES, LP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_s;
  key_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             press_entry;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n_i};
  end

  assign key_s = sync_q[1];

  // The edge on which a debounced press is accepted.
  assign press_entry = (state_q == PRESS_WAIT) && !key_s && (cnt_q == DB_LAST);

  // Debounce FSM with registered level and one-cycle press/release pulses.
  // Reset parks in RELEASE_WAIT so a key held through reset is absorbed
  // silently, and release only pulses when a debounced press was reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RELEASE_WAIT;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!key_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (key_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= level_q;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_CONDITIONER_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_PRE  = CNT_W'(LP_CYCLES - 2);

  logic [CNT_W-1:0] lp_cnt_q;
  logic             long_done_q;
  logic             long_q;

  // Hold timer: starts at press acceptance, keeps running through glitches
  // absorbed by RELEASE_WAIT, saturates, and fires once per accepted press.
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_cnt_q    <= '0;
      long_done_q <= 1'b1;
      long_q      <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_entry) begin
        lp_cnt_q    <= '0;
        long_done_q <= 1'b0;
      end else if (state_q == HELD || state_q == RELEASE_WAIT) begin
        if (lp_cnt_q != LP_LAST) lp_cnt_q <= lp_cnt_q + 1'b1;
        if (state_q == HELD && !long_done_q && lp_cnt_q >= LP_PRE) begin
          long_q      <= 1'b1;
          long_done_q <= 1'b1;
        end
      end
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: four independent key_debounce lanes behind one key bundle.
// Build option KEY_CONDITIONER_LONG_PRESS_EN enables the key_long pulses.
module key_conditioner
  import timer_pkg::*;
#(
  parameter int FREQ_MHZ    = 50,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input logic              clk,
  input logic              rst,
  key_conditioner_if.slave kif
);

  localparam int DB_CYCLES = FREQ_MHZ * 1000 * DEBOUNCE_MS;
  localparam int LP_CYCLES = FREQ_MHZ * 1000 * LONG_MS;

  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] press_w;
  logic [NUM_KEYS-1:0] release_w;
  logic [NUM_KEYS-1:0] long_w;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .LP_CYCLES (LP_CYCLES)
    ) u_key (
      .clk       (clk),
      .rst       (rst),
      .key_n_i   (kif.key_n[gi]),
      .level_o   (level_w[gi]),
      .press_o   (press_w[gi]),
      .release_o (release_w[gi]),
      .long_o    (long_w[gi])
    );
  end

  assign kif.key_level   = level_w;
  assign kif.key_press   = press_w;
  assign kif.key_release = release_w;
  assign kif.key_long    = long_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with DB_CYCLES=1000, LP_CYCLES=3000.
// Expected pulses are queued with their cycle when stimulus is driven; a
// negedge monitor pops and compares them, and flags any unexpected pulse.
module tb_key_conditioner;
  import timer_pkg::*;

  localparam int DB  = 1000;
  localparam int LAT = DB + 2;
  localparam int LP  = 3000;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_conditioner_if kif();

  key_conditioner #(
    .FREQ_MHZ    (1),
    .DEBOUNCE_MS (1),
    .LONG_MS     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Scoreboard monitor: every cycle the pulse outputs must match the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_event cyc=%0d: required press=%b release=%b long=%b, never seen",
                 exp_q[0].cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].lng);
        void'(exp_q.pop_front());
      end
      n_vec++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if ({kif.key_press, kif.key_release, kif.key_long} !==
            {exp_q[0].press, exp_q[0].rel, exp_q[0].lng}) begin
          n_err++;
          $display("FAIL pulse_event cyc=%0d got press=%b release=%b long=%b required press=%b release=%b long=%b",
                   cyc, kif.key_press, kif.key_release, kif.key_long,
                   exp_q[0].press, exp_q[0].rel, exp_q[0].lng);
        end else begin
          $display("event cyc=%0d press=%b release=%b long=%b ok",
                   cyc, kif.key_press, kif.key_release, kif.key_long);
        end
        void'(exp_q.pop_front());
      end else if ({kif.key_press, kif.key_release, kif.key_long} !== 12'h000) begin
        n_err++;
        $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b long=%b required all 0",
                 cyc, kif.key_press, kif.key_release, kif.key_long);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l;
    exp_q.push_back(e);
  endtask

  // Reset state, with KEY_WRITE held low through reset release.
  task automatic test_reset();
    int r0;
    rst = 1'b1;
    kif.key_n = 4'b1011;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
    n_vec++;
    if ({kif.key_level, kif.key_press, kif.key_release, kif.key_long} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_outputs got %h required 0000",
               {kif.key_level, kif.key_press, kif.key_release, kif.key_long});
    end
    rst = 1'b0;
    r0 = cyc + 1;
    wait_cyc(r0 + 1200);
    n_vec++;
    if (kif.key_level !== 4'b0000) begin
      n_err++;
      $display("FAIL held_through_reset_level got %b required 0000", kif.key_level);
    end
    $display("reset: outputs cleared, held key absorbed");
  endtask

  // KEY_WRITE released for 1100 cycles and pressed again -> one press.
  task automatic test_held_at_reset();
    int base, rbase;
    logic [3:0] m;
    m = 4'(1 << KEY_WRITE);
    kif.key_n[KEY_WRITE] = 1'b1;
    wait_cyc(cyc + 1100);
    kif.key_n[KEY_WRITE] = 1'b0;
    base = cyc + 1;
    push(base + LAT, m, 4'b0, 4'b0);
    wait_cyc(base + LAT - 1);
    n_vec++;
    if (kif.key_level[KEY_WRITE] !== 1'b0) begin
      n_err++;
      $display("FAIL repress_level_early got %b required 0", kif.key_level[KEY_WRITE]);
    end
    wait_cyc(base + LAT);
    n_vec++;
    if (kif.key_level[KEY_WRITE] !== 1'b1) begin
      n_err++;
      $display("FAIL repress_level got %b required 1", kif.key_level[KEY_WRITE]);
    end
    wait_cyc(base + 1200);
    kif.key_n[KEY_WRITE] = 1'b1;
    rbase = cyc + 1;
    push(rbase + LAT, 4'b0, m, 4'b0);
    wait_cyc(rbase + LAT + 10);
    $display("held_at_reset: repress base=%0d release base=%0d", base, rbase);
  endtask

  // Clean press on KEY_START, glitch while held, then release.
  task automatic test_press_release();
    int base, rbase;
    logic [3:0] m;
    m = 4'(1 << KEY_START);
    kif.key_n[KEY_START] = 1'b0;
    base = cyc + 1;
    push(base + LAT, m, 4'b0, 4'b0);
    wait_cyc(base + LAT - 1);
    n_vec++;
    if (kif.key_level[KEY_START] !== 1'b0) begin
      n_err++;
      $display("FAIL press_level_early got %b required 0", kif.key_level[KEY_START]);
    end
    wait_cyc(base + LAT);
    n_vec++;
    if (kif.key_level[KEY_START] !== 1'b1) begin
      n_err++;
      $display("FAIL press_level got %b required 1", kif.key_level[KEY_START]);
    end
    wait_cyc(base + 1200);
    kif.key_n[KEY_START] = 1'b1;
    wait_cyc(cyc + 20);
    kif.key_n[KEY_START] = 1'b0;
    wait_cyc(cyc + 100);
    n_vec++;
    if (kif.key_level[KEY_START] !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_level got %b required 1", kif.key_level[KEY_START]);
    end
    kif.key_n[KEY_START] = 1'b1;
    rbase = cyc + 1;
    push(rbase + LAT, 4'b0, m, 4'b0);
    wait_cyc(rbase + LAT - 1);
    n_vec++;
    if (kif.key_level[KEY_START] !== 1'b1) begin
      n_err++;
      $display("FAIL release_level_early got %b required 1", kif.key_level[KEY_START]);
    end
    wait_cyc(rbase + LAT);
    n_vec++;
    if (kif.key_level[KEY_START] !== 1'b0) begin
      n_err++;
      $display("FAIL release_level got %b required 0", kif.key_level[KEY_START]);
    end
    wait_cyc(cyc + 10);
    $display("press_release: press base=%0d release base=%0d", base, rbase);
  endtask

  // KEY_RESET low 500, high 10, then low held -> press at cycle 1512.
  task automatic test_bounce();
    int base, rbase;
    logic [3:0] m;
    m = 4'(1 << KEY_RESET);
    kif.key_n[KEY_RESET] = 1'b0;
    base = cyc + 1;
    push(base + 1512, m, 4'b0, 4'b0);
    wait_cyc(base + 499);
    kif.key_n[KEY_RESET] = 1'b1;
    wait_cyc(base + 509);
    kif.key_n[KEY_RESET] = 1'b0;
    wait_cyc(base + 1511);
    n_vec++;
    if (kif.key_level[KEY_RESET] !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_level_early got %b required 0", kif.key_level[KEY_RESET]);
    end
    wait_cyc(base + 1512);
    n_vec++;
    if (kif.key_level[KEY_RESET] !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_level got %b required 1", kif.key_level[KEY_RESET]);
    end
    wait_cyc(base + 1600);
    kif.key_n[KEY_RESET] = 1'b1;
    rbase = cyc + 1;
    push(rbase + LAT, 4'b0, m, 4'b0);
    wait_cyc(rbase + LAT + 10);
    $display("bounce: base=%0d", base);
  endtask

  // KEY_SHOW held 5000 cycles: press at 1002, long at 4001 when enabled.
  task automatic test_long();
    int base, rbase;
    logic [3:0] m;
    m = 4'(1 << KEY_SHOW);
    kif.key_n[KEY_SHOW] = 1'b0;
    base = cyc + 1;
    push(base + LAT, m, 4'b0, 4'b0);
    if (LONG_EN) push(base + LAT + LP - 1, 4'b0, 4'b0, m);
    wait_cyc(base + LAT + LP - 1);
    n_vec++;
    if (kif.key_long !== (LONG_EN ? m : 4'b0000)) begin
      n_err++;
      $display("FAIL long_pulse got %b required %b", kif.key_long, LONG_EN ? m : 4'b0000);
    end
    wait_cyc(base + 4999);
    kif.key_n[KEY_SHOW] = 1'b1;
    rbase = cyc + 1;
    push(rbase + LAT, 4'b0, m, 4'b0);
    wait_cyc(rbase + LAT + 10);
    $display("long: base=%0d long_enabled=%0d", base, LONG_EN);
  endtask

  // All keys together, then reset mid-press: level drops, no releases.
  task automatic test_simultaneous();
    int base;
    kif.key_n = 4'b0000;
    base = cyc + 1;
    push(base + LAT, 4'b1111, 4'b0, 4'b0);
    wait_cyc(base + 1500);
    n_vec++;
    if (kif.key_level !== 4'b1111) begin
      n_err++;
      $display("FAIL simul_level got %b required 1111", kif.key_level);
    end
    rst = 1'b1;
    wait_cyc(base + 1501);
    n_vec++;
    if (kif.key_level !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_mid_press_level got %b required 0000", kif.key_level);
    end
    rst = 1'b0;
    wait_cyc(cyc + 1200);
    kif.key_n = 4'b1111;
    wait_cyc(cyc + 1200);
    n_vec++;
    if (kif.key_level !== 4'b0000) begin
      n_err++;
      $display("FAIL post_reset_release_level got %b required 0000", kif.key_level);
    end
    $display("simultaneous: base=%0d", base);
  endtask

  initial begin
    kif.key_n = 4'b1111;
    @(negedge clk);
    test_reset();
    test_held_at_reset();
    test_press_release();
    test_bounce();
    test_long();
    test_simultaneous();
    wait_cyc(cyc + 5);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drained got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter FREQ_MHZ, default 50: clock frequency in MHz.
REQ-002 Parameter DEBOUNCE_MS, default 10: required stable time; DB_CYCLES = FREQ_MHZ*1000*DEBOUNCE_MS.
REQ-003 Parameter LONG_MS, default 1000: long-press hold time; LP_CYCLES = FREQ_MHZ*1000*LONG_MS.
REQ-004 clk  input  1  system clock; all logic SHALL be on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 key_n  input  4  raw board keys, asynchronous, active-low (0 = pressed).
REQ-007 key_level  output  4  debounced state per key, 1 = pressed.
REQ-008 key_press  output  4  one-cycle pulse per debounced press.
REQ-009 key_release  output  4  one-cycle pulse per debounced release.
REQ-010 key_long  output  4  one-cycle pulse when a press has been held LP_CYCLES.

Function
REQ-011 Each key SHALL pass a 2-flop synchronizer, then an independent debounce FSM; keys never interact, and any combination SHALL pulse in the same cycle.
REQ-012 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; one counter per key, width $clog2(max(DB_CYCLES, LP_CYCLES)+1).
REQ-013 IDLE: synced key = 0 -> PRESS_WAIT, counter cleared.
REQ-014 PRESS_WAIT: synced key = 1 -> IDLE, counter cleared (bounce rejected); counter reaching DB_CYCLES-1 with key still 0 -> HELD.
REQ-015 Entry into HELD SHALL assert key_press for exactly the entry cycle and set key_level to 1 on the same edge.
REQ-016 HELD: synced key = 1 -> RELEASE_WAIT, counter cleared; otherwise the counter keeps counting for long-press timing.
REQ-017 RELEASE_WAIT: synced key = 0 -> HELD, counter not restarted for long-press purposes, no pulse; counter reaching DB_CYCLES-1 with key 1 -> IDLE, key_release pulse for one cycle, key_level to 0.
REQ-018 Press latency: key_press SHALL assert exactly 2 + DB_CYCLES cycles after a clean falling edge of key_n is sampled.
REQ-019 Counters SHALL saturate and never wrap.

Reset
REQ-020 rst SHALL force all FSMs to RELEASE_WAIT with counter 0, synchronizer flops to 1, and all outputs to 0.
REQ-021 A key held through reset release SHALL NOT produce key_press until it has been released for DB_CYCLES and pressed again.
REQ-022 rst asserted mid-press SHALL drop key_level on the next edge and produce no key_release pulse.

Configuration
REQ-023 Macro KEY_CONDITIONER_LONG_PRESS_EN defined: in HELD, a counter reaching LP_CYCLES-1 SHALL pulse key_long once per press; the pulse does not repeat and a glitch absorbed by RELEASE_WAIT does not rearm it.
REQ-024 Macro undefined: key_long SHALL be constant 0 and the long-press counting logic SHALL be absent.

Structure
REQ-025 Package timer_pkg SHALL hold the FSM state enumeration and the key index constants KEY_RESET=0, KEY_START=1, KEY_WRITE=2, KEY_SHOW=3.
REQ-026 Sub-module key_debounce SHALL implement one synchronizer, FSM and counter; key_conditioner SHALL instantiate it 4 times via generate.
REQ-027 Downstream timer logic SHALL use key_press bits in place of its own edge detectors.

Verification (FREQ_MHZ=1, DEBOUNCE_MS=1 -> DB_CYCLES=1000; LONG_MS=3 -> LP_CYCLES=3000)
REQ-028 Clean press: key_n[1] goes 1->0 at cycle 0 and is held -> key_press[1] high only at cycle 1002, key_level[1] high from 1002.
REQ-029 Bounce: key_n[0] low for 500 cycles, high 10, low held -> no pulse before cycle 1512, single key_press[0] at 1512 (±1 for sampling alignment, fixed by bench).
REQ-030 Release: after REQ-028, key_n[1] goes back to 1 and is held -> one key_release[1] 1002 cycles later, key_level[1] 0; a 20-cycle high glitch while held -> no pulses.
REQ-031 Held at reset: key_n[2] = 0 during and after rst -> no key_press[2]; release for 1100 cycles, press again -> one key_press[2].
REQ-032 Long press (macro defined): key_n[3] held 5000 cycles -> key_press[3] at 1002, a single key_long[3] at 1002+2999; with the macro undefined, key_long stays 0.
REQ-033 Simultaneous: all key_n fall at the same cycle -> key_press = 4'b1111 for one cycle at 1002; rst at cycle 1500 -> key_level = 0 at 1501 with no release pulses.
